// File: rtl/seq_mult_addshift.sv
// Sequential add-shift multiplier, W x W -> 2W, one partial-product step per clock.
// Signed mode subtracts on the final step to weight the operand sign bit negatively.
module seq_mult_addshift #(
   parameter int unsigned W = 8
) (
   input  logic           Clk,
   input  logic           Reset_n,
   input  logic           Start,
   input  logic           Signed_mode,
   input  logic [W-1:0]   Multiplicand,
   input  logic [W-1:0]   Multiplier,
   output logic [2*W-1:0] Product,
   output logic           X,
   output logic           Busy,
   output logic           Done
);

   localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e          state_q;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic [W-1:0]    s_q;
   logic [CW-1:0]   count_q;
   logic            mode_q;

   logic            last_step;
   logic [W:0]      ext_a;
   logic [W:0]      ext_s;
   logic [W:0]      sum;

   always_comb begin
      last_step = (count_q == CW'(W - 1));
      ext_a     = {mode_q & a_q[W-1], a_q};
      ext_s     = {mode_q & s_q[W-1], s_q};
      sum       = ext_a;
      if (b_q[0]) begin
         sum = (mode_q && last_step) ? (ext_a - ext_s) : (ext_a + ext_s);
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         count_q <= '0;
         mode_q  <= 1'b0;
         Product <= '0;
         X       <= 1'b0;
         Busy    <= 1'b0;
         Done    <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state_q)
            StIdle: begin
               if (Start) begin
                  state_q <= StRun;
                  s_q     <= Multiplicand;
                  b_q     <= Multiplier;
                  mode_q  <= Signed_mode;
                  a_q     <= '0;
                  X       <= 1'b0;
                  count_q <= '0;
                  Busy    <= 1'b1;
               end
            end
            StRun: begin
               // The shifted-out sum LSB enters B from the top as B's consumed bits leave.
               a_q     <= sum[W:1];
               b_q     <= {sum[0], b_q[W-1:1]};
               X       <= sum[W];
               count_q <= count_q + 1'b1;
               if (last_step) begin
                  state_q <= StDone;
                  Busy    <= 1'b0;
                  Done    <= 1'b1;
                  Product <= {sum, b_q[W-1:1]};
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mult_addshift.sv
// Scoreboard bench for seq_mult_addshift: W=8 and W=4 instances checked against
// plain integer multiplication, with latency, pulse width and busy length checks.
module tb_seq_mult_addshift;

   typedef struct {
      logic [15:0] prod;
      int          t0;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int total = 0;
   int bad   = 0;

   logic        rst8_n, start8, mode8, x8, busy8, done8;
   logic [7:0]  mc8, mp8;
   logic [15:0] prod8;
   logic        rst4_n, start4, mode4, x4, busy4, done4;
   logic [3:0]  mc4, mp4;
   logic [7:0]  prod4;

   exp_t q8[$];
   exp_t q4[$];
   exp_t e8, e4;
   logic prev_done8 = 1'b0;
   logic prev_done4 = 1'b0;

   seq_mult_addshift #(.W(8)) dut8 (
      .Clk(clk), .Reset_n(rst8_n), .Start(start8), .Signed_mode(mode8),
      .Multiplicand(mc8), .Multiplier(mp8), .Product(prod8), .X(x8),
      .Busy(busy8), .Done(done8)
   );

   seq_mult_addshift #(.W(4)) dut4 (
      .Clk(clk), .Reset_n(rst4_n), .Start(start4), .Signed_mode(mode4),
      .Multiplicand(mc4), .Multiplier(mp4), .Product(prod4), .X(x4),
      .Busy(busy4), .Done(done4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: exact integer product of the operands as interpreted by the mode.
   function automatic logic [15:0] ref_mul(input int w, input bit mode, input int a, input int b);
      int sa, sb, p;
      sa = a;
      sb = b;
      if (mode && a >= (1 << (w - 1))) sa = a - (1 << w);
      if (mode && b >= (1 << (w - 1))) sb = b - (1 << w);
      p = sa * sb;
      return 16'(p & ((1 << (2 * w)) - 1));
   endfunction

   always @(negedge clk) begin
      if (prev_done8) chk("done8_width", 32'(done8), 32'd0);
      prev_done8 = done8 && rst8_n;
      if (rst8_n && done8) begin
         if (q8.size() == 0) begin
            chk("done8_unexpected", 32'(done8), 32'd0);
         end else begin
            e8 = q8.pop_front();
            chk("prod8", 32'(prod8), 32'(e8.prod));
            chk("x8", 32'(x8), 32'(e8.prod[15]));
            chk("lat8", cyc, e8.t0 + 8);
         end
      end
   end

   always @(negedge clk) begin
      if (prev_done4) chk("done4_width", 32'(done4), 32'd0);
      prev_done4 = done4 && rst4_n;
      if (rst4_n && done4) begin
         if (q4.size() == 0) begin
            chk("done4_unexpected", 32'(done4), 32'd0);
         end else begin
            e4 = q4.pop_front();
            chk("prod4", 32'(prod4), 32'(e4.prod[7:0]));
            chk("x4", 32'(x4), 32'(e4.prod[7]));
            chk("lat4", cyc, e4.t0 + 4);
         end
      end
   end

   // One W=8 operation; inputs are scrambled during the run, optionally with Start pulses.
   task automatic op8(input bit mode, input logic [7:0] a, input logic [7:0] b, input bit repulse);
      int t0, nb;
      @(negedge clk);
      start8 = 1'b1; mode8 = mode; mc8 = a; mp8 = b;
      t0 = cyc + 1;
      q8.push_back('{prod: ref_mul(8, mode, 32'(a), 32'(b)), t0: t0});
      nb = 0;
      for (int c = 0; c <= 9; c++) begin
         @(negedge clk);
         if (busy8) nb++;
         start8 = (repulse && c <= 8) ? 1'($urandom % 2) : 1'b0;
         mode8  = 1'($urandom % 2);
         mc8    = 8'($urandom);
         mp8    = 8'($urandom);
      end
      chk("busy8_cycles", nb, 8);
   endtask

   task automatic op4(input bit mode, input logic [3:0] a, input logic [3:0] b);
      int t0, nb;
      @(negedge clk);
      start4 = 1'b1; mode4 = mode; mc4 = a; mp4 = b;
      t0 = cyc + 1;
      q4.push_back('{prod: ref_mul(4, mode, 32'(a), 32'(b)), t0: t0});
      nb = 0;
      for (int c = 0; c <= 5; c++) begin
         @(negedge clk);
         if (busy4) nb++;
         start4 = 1'b0;
         mode4  = 1'($urandom % 2);
         mc4    = 4'($urandom);
         mp4    = 4'($urandom);
      end
      chk("busy4_cycles", nb, 4);
   endtask

   initial begin
      int t0;
      rst8_n = 1'b0; start8 = 1'b0; mode8 = 1'b0; mc8 = '0; mp8 = '0;
      rst4_n = 1'b0; start4 = 1'b0; mode4 = 1'b0; mc4 = '0; mp4 = '0;
      repeat (3) @(negedge clk);
      rst8_n = 1'b1; rst4_n = 1'b1;
      @(negedge clk);
      chk("rst_prod8", 32'(prod8), 32'd0);
      chk("rst_busy8", 32'(busy8), 32'd0);
      chk("rst_done8", 32'(done8), 32'd0);
      chk("rst_x8", 32'(x8), 32'd0);
      chk("rst_prod4", 32'(prod4), 32'd0);
      chk("rst_busy4", 32'(busy4), 32'd0);

      op8(1'b1, 8'h07, 8'hFD, 1'b0);
      op8(1'b1, 8'h80, 8'h80, 1'b0);
      op8(1'b1, 8'h7F, 8'h80, 1'b0);
      op8(1'b0, 8'hFF, 8'hFF, 1'b0);
      op8(1'b1, 8'hFF, 8'hFF, 1'b1);

      // Start held high: the second operation starts two edges after DONE.
      @(negedge clk);
      start8 = 1'b1; mode8 = 1'b1; mc8 = 8'h07; mp8 = 8'hFD;
      t0 = cyc + 1;
      q8.push_back('{prod: ref_mul(8, 1'b1, 7, 253), t0: t0});
      @(negedge clk);
      mode8 = 1'b0; mc8 = 8'h80; mp8 = 8'hC3;
      q8.push_back('{prod: ref_mul(8, 1'b0, 128, 195), t0: t0 + 10});
      while (cyc < t0 + 10) @(negedge clk);
      start8 = 1'b0;
      while (cyc < t0 + 21) @(negedge clk);

      // Reset in the middle of a run discards the partial result.
      op8(1'b1, 8'h7F, 8'h80, 1'b0);
      @(negedge clk);
      start8 = 1'b1; mode8 = 1'b0; mc8 = 8'hAB; mp8 = 8'hCD;
      t0 = cyc + 1;
      q8.push_back('{prod: ref_mul(8, 1'b0, 171, 205), t0: t0});
      @(negedge clk);
      start8 = 1'b0;
      while (cyc < t0 + 3) @(negedge clk);
      rst8_n = 1'b0;
      @(negedge clk);
      rst8_n = 1'b1;
      q8.delete();
      chk("midrst_busy8", 32'(busy8), 32'd0);
      chk("midrst_done8", 32'(done8), 32'd0);
      chk("midrst_prod8", 32'(prod8), 32'd0);
      chk("midrst_x8", 32'(x8), 32'd0);
      op8(1'b0, 8'd5, 8'd6, 1'b0);

      for (int i = 0; i < 30; i++) begin
         op8(1'($urandom % 2), 8'($urandom), 8'($urandom), 1'($urandom % 2));
      end

      op4(1'b1, 4'h8, 4'h7);
      op4(1'b0, 4'hF, 4'hF);
      op4(1'b1, 4'h8, 4'h8);
      for (int i = 0; i < 20; i++) begin
         op4(1'($urandom % 2), 4'($urandom), 4'($urandom));
      end

      repeat (3) @(negedge clk);
      chk("q8_drained", q8.size(), 0);
      chk("q4_drained", q4.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
